shared_pipe_arbiter: RTL and testbench



---
 rtl/shared_pipe_pkg.sv | 15 +
 rtl/shared_pipe_arbiter_rr_pick.sv | 35 +++
 rtl/shared_pipe_arbiter.sv | 134 +++++++++++++
 tb/tb_shared_pipe_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_pipe_pkg.sv
// Shared types and helpers for the shared pipeline arbiter.
package shared_pipe_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int BURST_CNT_W = 8;

    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/shared_pipe_arbiter_rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;

    // The upper copy of req supplies the wrapped candidates below ptr.
    always_comb begin
        dbl    = {req, req};
        masked = '0;
        for (int i = 0; i < 2*N; i++) begin
            masked[i] = dbl[i] && (i >= int'(ptr));
        end
        any = 1'b0;
        idx = '0;
        for (int i = 0; i < 2*N; i++) begin
            if (!any && masked[i]) begin
                any = 1'b1;
                idx = ID_W'(i % N);
            end
        end
        grant = '0;
        if (any) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/shared_pipe_arbiter.sv
// Round-robin, burst-limited arbiter feeding a shared two-stage pipeline.
//   state | meaning
//   ARB   | search for a winner starting at ptr
//   HOLD  | owner keeps the grant until MAX_BURST beats or it drops valid
module shared_pipe_arbiter
    import shared_pipe_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      busy
);

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d, owner_q, owner_d;
    logic [BURST_CNT_W-1:0] burst_q, burst_d, burst_inc;

    logic                   s1_valid, s2_valid;
    logic [ID_W-1:0]        s1_id, s2_id;
    logic [DATA_W-1:0]      s1_data, s2_data;

    logic                   adv, hold_keep, issue, grant_any;
    logic [ID_W-1:0]        search_ptr, owner_next, grant_idx;
    logic [ID_W-1:0]        pick_idx;
    logic [NUM_REQ-1:0]     pick_grant, ready_vec;
    logic                   pick_any;

    assign adv        = !s2_valid || rsp_ready;
    assign owner_next = ID_W'(rr_next(int'(owner_q), NUM_REQ));
    assign hold_keep  = (state_q == HOLD) && req_valid[owner_q];
    assign burst_inc  = (burst_q == '1) ? burst_q : burst_q + 1'b1;

    // A dropped owner hands over in the same cycle, searching from owner+1.
    assign search_ptr = (state_q == HOLD) ? owner_next : ptr_q;

    rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req   (req_valid),
        .ptr   (search_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        grant_idx = hold_keep ? owner_q : pick_idx;
        grant_any = hold_keep || pick_any;
        ready_vec = hold_keep ? (NUM_REQ'(1) << owner_q) : pick_grant;
        issue     = rst_n && adv && grant_any;
        req_ready = issue ? ready_vec : '0;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        burst_d = burst_q;
        if (adv) begin
            if (hold_keep) begin
                burst_d = burst_inc;
                if (burst_inc >= BURST_CNT_W'(MAX_BURST)) begin
                    ptr_d   = owner_next;
                    burst_d = '0;
                    state_d = ARB;
                end
            end else begin
                if (state_q == HOLD) begin
                    ptr_d   = owner_next;
                    burst_d = '0;
                    state_d = ARB;
                end
                if (issue) begin
                    owner_d = grant_idx;
                    burst_d = BURST_CNT_W'(1);
                    if (MAX_BURST > 1) begin
                        state_d = HOLD;
                    end else begin
                        state_d = ARB;
                        ptr_d   = ID_W'(rr_next(int'(grant_idx), NUM_REQ));
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB;
            ptr_q   <= '0;
            owner_q <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            burst_q <= burst_d;
        end
    end

    // Stage 2 holds inverted data, so its reset value of all ones reads out as zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            s2_id    <= '0;
            s2_data  <= '1;
        end else if (adv) begin
            s1_valid <= issue;
            s1_id    <= grant_idx;
            s1_data  <= req_data[int'(grant_idx)*DATA_W +: DATA_W];
            s2_valid <= s1_valid;
            s2_id    <= s1_id;
            s2_data  <= ~s1_data;
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_id    = s2_id;
    assign rsp_data  = ~s2_data;
    assign busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_shared_pipe_arbiter.sv
// Scoreboard bench: a 4-requester/burst-4 instance and a 3-requester/burst-1 instance.
module tb_shared_pipe_arbiter;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n_a, rst_n_b;
    logic [3:0]  req_valid_a, req_ready_a;
    logic [31:0] req_data_a;
    logic        rsp_valid_a, rsp_ready_a, busy_a;
    logic [7:0]  rsp_data_a;
    logic [1:0]  rsp_id_a;
    logic [2:0]  req_valid_b, req_ready_b;
    logic [23:0] req_data_b;
    logic        rsp_valid_b, rsp_ready_b, busy_b;
    logic [7:0]  rsp_data_b;
    logic [1:0]  rsp_id_b;

    exp_t q_a[$], q_b[$];
    int   ids_a[$], ids_b[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    shared_pipe_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .req_valid(req_valid_a), .req_data(req_data_a),
        .req_ready(req_ready_a), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
        .rsp_data(rsp_data_a), .rsp_id(rsp_id_a), .busy(busy_a)
    );

    shared_pipe_arbiter #(.NUM_REQ(3), .DATA_W(8), .MAX_BURST(1)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .req_valid(req_valid_b), .req_data(req_data_b),
        .req_ready(req_ready_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
        .rsp_data(rsp_data_b), .rsp_id(rsp_id_b), .busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: observe handshakes at negedge, then refresh accepted lanes after posedge.
    task automatic cyc();
        exp_t       e;
        logic [3:0] acc_a;
        logic [2:0] acc_b;
        acc_a = '0;
        acc_b = '0;
        @(negedge clk);
        if (rst_n_a) begin
            chk("a_ready_onehot", 32'($countones(req_ready_a) <= 1), 32'd1);
            chk("a_ready_without_valid", 32'(req_ready_a & ~req_valid_a), 32'd0);
            for (int i = 0; i < 4; i++) begin
                if (req_valid_a[i] && req_ready_a[i]) begin
                    e.id = i;
                    e.data = req_data_a[i*8 +: 8];
                    q_a.push_back(e);
                    acc_a[i] = 1'b1;
                end
            end
            if (rsp_valid_a && rsp_ready_a) begin
                chk("a_sb_nonempty", 32'(q_a.size() > 0), 32'd1);
                if (q_a.size() > 0) begin
                    e = q_a.pop_front();
                    chk("a_rsp_id", 32'(rsp_id_a), 32'(e.id));
                    chk("a_rsp_data", 32'(rsp_data_a), 32'(e.data));
                    ids_a.push_back(int'(rsp_id_a));
                end
            end
        end
        if (rst_n_b) begin
            chk("b_ready_onehot", 32'($countones(req_ready_b) <= 1), 32'd1);
            chk("b_ready_without_valid", 32'(req_ready_b & ~req_valid_b), 32'd0);
            for (int i = 0; i < 3; i++) begin
                if (req_valid_b[i] && req_ready_b[i]) begin
                    e.id = i;
                    e.data = req_data_b[i*8 +: 8];
                    q_b.push_back(e);
                    acc_b[i] = 1'b1;
                end
            end
            if (rsp_valid_b && rsp_ready_b) begin
                chk("b_sb_nonempty", 32'(q_b.size() > 0), 32'd1);
                if (q_b.size() > 0) begin
                    e = q_b.pop_front();
                    chk("b_rsp_id", 32'(rsp_id_b), 32'(e.id));
                    chk("b_rsp_data", 32'(rsp_data_b), 32'(e.data));
                    ids_b.push_back(int'(rsp_id_b));
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (acc_a[i]) req_data_a[i*8 +: 8] = 8'($urandom);
        for (int i = 0; i < 3; i++) if (acc_b[i]) req_data_b[i*8 +: 8] = 8'($urandom);
    endtask

    task automatic reset_all();
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        req_valid_a = '0;
        req_valid_b = '0;
        rsp_ready_a = 1'b1;
        rsp_ready_b = 1'b1;
        cyc();
        cyc();
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        q_a.delete();
        q_b.delete();
    endtask

    task automatic drain_a();
        req_valid_a = '0;
        rsp_ready_a = 1'b1;
        for (int k = 0; k < 20 && (q_a.size() > 0 || busy_a); k++) cyc();
        chk("a_drained", 32'(q_a.size()), 32'd0);
    endtask

    task automatic drain_b();
        req_valid_b = '0;
        rsp_ready_b = 1'b1;
        for (int k = 0; k < 20 && (q_b.size() > 0 || busy_b); k++) cyc();
        chk("b_drained", 32'(q_b.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp3[6];
        exp3 = '{2, 2, 3, 3, 3, 3};

        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        req_valid_a = 4'hF;
        req_valid_b = '0;
        req_data_a = $urandom;
        req_data_b = 24'($urandom);
        rsp_ready_a = 1'b1;
        rsp_ready_b = 1'b1;

        // Reset state, with req_ready held low despite valid requests
        @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data_a), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id_a), 32'd0);
        chk("rst_req_ready", 32'(req_ready_a), 32'd0);
        chk("rst_b_rsp_data", 32'(rsp_data_b), 32'd0);
        cyc();
        req_valid_a = '0;
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        // T1: single beat from requester 1
        req_valid_a = 4'b0010;
        req_data_a[15:8] = 8'hA5;
        cyc();
        req_valid_a = '0;
        chk("t1_busy_s1", 32'(busy_a), 32'd1);
        chk("t1_valid_early", 32'(rsp_valid_a), 32'd0);
        cyc();
        chk("t1_rsp_valid", 32'(rsp_valid_a), 32'd1);
        chk("t1_rsp_data", 32'(rsp_data_a), 32'hA5);
        chk("t1_rsp_id", 32'(rsp_id_a), 32'd1);
        chk("t1_busy_s2", 32'(busy_a), 32'd1);
        cyc();
        chk("t1_busy_after", 32'(busy_a), 32'd0);
        chk("t1_valid_after", 32'(rsp_valid_a), 32'd0);

        // T2: all requesters valid, bursts of four
        reset_all();
        ids_a.delete();
        req_valid_a = 4'hF;
        repeat (22) cyc();
        chk("t2_beat_count", 32'(ids_a.size()), 32'd20);
        for (int k = 0; k < 20 && k < ids_a.size(); k++)
            chk($sformatf("t2_id_%0d", k), 32'(ids_a[k]), 32'((k / 4) % 4));
        drain_a();

        // T3: owner 2 drops after two beats, requester 3 takes over at once
        reset_all();
        ids_a.delete();
        req_valid_a = 4'b0100;
        repeat (2) cyc();
        req_valid_a = 4'b1000;
        #1;
        chk("t3_handover_ready", 32'(req_ready_a), 32'b1000);
        repeat (4) cyc();
        chk("t3_no_idle", 32'(ids_a.size() + q_a.size()), 32'd6);
        drain_a();
        chk("t3_count", 32'(ids_a.size()), 32'd6);
        for (int k = 0; k < 6 && k < ids_a.size(); k++)
            chk($sformatf("t3_id_%0d", k), 32'(ids_a[k]), 32'(exp3[k]));

        // T4: five stall cycles on a full pipe
        reset_all();
        ids_a.delete();
        req_valid_a = 4'hF;
        repeat (3) cyc();
        rsp_ready_a = 1'b0;
        for (int s = 0; s < 5; s++) begin
            cyc();
            chk("t4_stall_ready", 32'(req_ready_a), 32'd0);
            chk("t4_stall_valid", 32'(rsp_valid_a), 32'd1);
            chk("t4_stall_sb", 32'(q_a.size()), 32'd2);
            if (q_a.size() > 0) begin
                chk("t4_stall_id", 32'(rsp_id_a), 32'(q_a[0].id));
                chk("t4_stall_data", 32'(rsp_data_a), 32'(q_a[0].data));
            end
        end
        rsp_ready_a = 1'b1;
        repeat (10) cyc();
        drain_a();
        chk("t4_count", 32'(ids_a.size()), 32'd13);
        for (int k = 0; k < 13 && k < ids_a.size(); k++)
            chk($sformatf("t4_id_%0d", k), 32'(ids_a[k]), 32'((k / 4) % 4));

        // T5: reset mid-burst of owner 2 with two beats in flight
        reset_all();
        req_valid_a = 4'b0100;
        repeat (3) cyc();
        chk("t5_busy_before", 32'(busy_a), 32'd1);
        rst_n_a = 1'b0;
        req_valid_a = 4'hF;
        #1;
        chk("t5_ready_in_reset", 32'(req_ready_a), 32'd0);
        cyc();
        q_a.delete();
        rst_n_a = 1'b1;
        ids_a.delete();
        chk("t5_rsp_valid", 32'(rsp_valid_a), 32'd0);
        chk("t5_busy", 32'(busy_a), 32'd0);
        #1;
        chk("t5_first_grant", 32'(req_ready_a), 32'b0001);
        cyc();
        chk("t5_nothing_emitted", 32'(rsp_valid_a), 32'd0);
        repeat (4) cyc();
        drain_a();
        chk("t5_count", 32'(ids_a.size()), 32'd5);
        for (int k = 0; k < 5 && k < ids_a.size(); k++)
            chk($sformatf("t5_id_%0d", k), 32'(ids_a[k]), 32'(k / 4));

        // T6: three requesters, single-beat bursts, random data
        ids_b.delete();
        req_valid_b = 3'b111;
        repeat (14) cyc();
        drain_b();
        chk("t6_count", 32'(ids_b.size()), 32'd14);
        for (int k = 0; k < 14 && k < ids_b.size(); k++)
            chk($sformatf("t6_id_%0d", k), 32'(ids_b[k]), 32'(k % 3));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
